// File: rtl/sfq_emu_pkg.sv
// rtl/sfq_emu_pkg.sv - shared types and constants for the SFQ cell emulators
package sfq_emu_pkg;

    // Combine function applied to the stored channel states on a tick
    typedef enum logic {
        OR  = 1'b0,
        AND = 1'b1
    } sfq_mode_e;

    // Width of the saturating violation counter
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Widest channel vector any cell of this family supports
    localparam int MAX_CH = 8;

    // Decide whether a tick fires given the stored states.
    // used marks the live channels; unused bits are forced neutral
    // (zero for OR, one for AND) so a narrow cell combines correctly.
    function automatic logic mode_fire(
        input sfq_mode_e         mode,
        input logic [MAX_CH-1:0] st,
        input logic [MAX_CH-1:0] used
    );
        if (mode == OR) begin
            return |(st & used);
        end
        return &(st | ~used);
    endfunction

endpackage

// File: rtl/sfq_pulse_det.sv
// rtl/sfq_pulse_det.sv - toggle-to-pulse detector for one toggle-encoded line
module sfq_pulse_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic prev;

    // Remember last cycle's level; in reset the live level is loaded so
    // the first cycle after release never reports a spurious pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= din;
        end else begin
            prev <= din;
        end
    end

    // A pulse is any level change; nothing is reported while in reset
    assign pulse = rst_n & (din ^ prev);

endmodule

// File: rtl/sfq_ornt_emu.sv
// rtl/sfq_ornt_emu.sv - clocked OR/AND SFQ cell emulator with timing-window checks
module sfq_ornt_emu
    import sfq_emu_pkg::*;
#(
    parameter int        N_IN     = 2,
    parameter sfq_mode_e MODE     = OR,
    parameter int        DLY_CYC  = 5,
    parameter int        CT_CYC   = 2,
    parameter int        HOLD_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN-1:0]      a,
    input  logic                 tick,
    input  logic                 err_clr,
    output logic                 q,
    output logic                 q_vld,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [N_IN-1:0]      st_o
);

    // Window counters hold the number of further cycles a window stays open
    localparam int               WIN_W   = 3;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    // A data pulse opens the setup window for CT_CYC cycles counting its
    // own cycle, so only CT_CYC-1 cycles remain once it is registered.
    localparam logic [WIN_W-1:0] SU_LOAD = WIN_W'((CT_CYC > 0) ? CT_CYC - 1 : 0);

    // A tick opens the hold window for the HOLD_CYC cycles that follow it
    localparam logic [WIN_W-1:0] HO_LOAD = WIN_W'(HOLD_CYC);

    // Live channel mask handed to the shared combine function
    localparam logic [MAX_CH-1:0] USED = MAX_CH'((9'd1 << N_IN) - 9'd1);

    // Fire delay line: fire_vec[k] is a fire seen k cycles ago
    localparam int PW = (DLY_CYC > 1) ? DLY_CYC - 1 : 1;

    logic [N_IN-1:0]  a_pls;
    logic             tick_pls;
    logic [N_IN-1:0]  st;
    logic [WIN_W-1:0] su_cnt;
    logic [WIN_W-1:0] ho_cnt;
    logic             data_any;
    logic             setup_v;
    logic             hold_v;
    logic             viol;
    logic             fire;
    logic [PW-1:0]    pipe;
    logic [PW:0]      fire_vec;

    for (genvar i = 0; i < N_IN; i++) begin : g_det_a
        sfq_pulse_det u_det_a (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (a[i]),
            .pulse (a_pls[i])
        );
    end

    sfq_pulse_det u_det_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tick),
        .pulse (tick_pls)
    );

    // Classify this cycle's pulses: setup/hold violations and tick fire.
    // A setup and a hold violation in one cycle collapse into one event.
    always_comb begin
        data_any = |a_pls;
        setup_v  = (CT_CYC > 0) && tick_pls && (data_any || (su_cnt != '0));
        hold_v   = (HOLD_CYC > 0) && data_any && (ho_cnt != '0);
        viol     = setup_v | hold_v;
        fire     = tick_pls && !viol && mode_fire(MODE, MAX_CH'(st), USED);
    end

    assign fire_vec = {pipe, fire};

    // Stored channel states: a tick evaluates and clears them, any data
    // pulse arriving alongside an accepted tick belongs to the next tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= '0;
        end else if (viol) begin
            st <= '0;
        end else if (tick_pls) begin
            st <= a_pls;
        end else begin
            st <= st | a_pls;
        end
    end

    // Setup and hold window counters; discarded pulses never re-arm them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            su_cnt <= '0;
            ho_cnt <= '0;
        end else begin
            if (data_any && !viol) begin
                su_cnt <= SU_LOAD;
            end else if (su_cnt != '0) begin
                su_cnt <= su_cnt - WIN_ONE;
            end

            if (tick_pls && !viol) begin
                ho_cnt <= HO_LOAD;
            end else if (ho_cnt != '0) begin
                ho_cnt <= ho_cnt - WIN_ONE;
            end
        end
    end

    // Sticky error tracking: a violation wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_vld   <= 1'b1;
            err_cnt <= '0;
        end else if (viol) begin
            q_vld <= 1'b0;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            q_vld <= 1'b1;
        end
    end

    // Delay line and output toggle; reset drops every fire still in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe <= '0;
            q    <= 1'b0;
        end else begin
            pipe <= fire_vec[PW-1:0];
            q    <= q ^ fire_vec[DLY_CYC-1];
        end
    end

    assign err  = viol;
    assign st_o = st;

endmodule

// File: tb/tb_sfq_ornt_emu.sv
// tb/tb_sfq_ornt_emu.sv - directed table-driven bench for sfq_ornt_emu
module tb_sfq_ornt_emu;
    import sfq_emu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a0, a1;
    logic       tick0, tick1, clr0, clr1;
    logic       q0, q1, v0, v1, e0, e1;
    logic [7:0] c0, c1;
    logic [3:0] s0, s1;

    always #5 clk = ~clk;

    sfq_ornt_emu #(
        .N_IN(4), .MODE(OR), .DLY_CYC(3), .CT_CYC(2), .HOLD_CYC(1)
    ) dut_or (
        .clk(clk), .rst_n(rst_n), .a(a0), .tick(tick0), .err_clr(clr0),
        .q(q0), .q_vld(v0), .err(e0), .err_cnt(c0), .st_o(s0)
    );

    sfq_ornt_emu #(
        .N_IN(4), .MODE(AND), .DLY_CYC(3), .CT_CYC(0), .HOLD_CYC(0)
    ) dut_and (
        .clk(clk), .rst_n(rst_n), .a(a1), .tick(tick1), .err_clr(clr1),
        .q(q1), .q_vld(v1), .err(e1), .err_cnt(c1), .st_o(s1)
    );

    typedef struct {
        int         cyc;
        bit         sel;
        logic [3:0] ta;
        logic       tt;
        logic       clr;
        logic       q;
        logic       vld;
        logic       err;
        logic [7:0] cnt;
        logic [3:0] st;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   bad;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int cyc, input int sel, input int ta, input int tt, input int clr,
                       input int q, input int vld, input int err, input int cnt, input int st);
        vec_t v;
        v.cyc = cyc;
        v.sel = sel[0];
        v.ta  = ta[3:0];
        v.tt  = tt[0];
        v.clr = clr[0];
        v.q   = q[0];
        v.vld = vld[0];
        v.err = err[0];
        v.cnt = cnt[7:0];
        v.st  = st[3:0];
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a0 = '0; a1 = '0; tick0 = 1'b0; tick1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;

        //   cyc sel ta      tt clr  q vld err cnt st
        add(  0, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add(  1, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 10, 0, 'b0100, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 11, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0100);
        add( 20, 0, 'b0000, 1, 0,   0, 1, 0,  0, 'b0100);
        add( 21, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 22, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 23, 0, 'b0000, 0, 0,   1, 1, 0,  0, 'b0000);
        add( 25, 0, 'b1001, 0, 0,   1, 1, 0,  0, 'b0000);
        add( 26, 0, 'b0000, 0, 0,   1, 1, 0,  0, 'b1001);
        add( 30, 0, 'b0000, 1, 0,   1, 1, 0,  0, 'b1001);
        add( 31, 0, 'b0000, 1, 0,   1, 1, 0,  0, 'b0000);
        add( 32, 0, 'b0000, 0, 0,   1, 1, 0,  0, 'b0000);
        add( 33, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 34, 0, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 40, 0, 'b0001, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 41, 0, 'b0000, 1, 0,   0, 1, 1,  0, 'b0001);
        add( 42, 0, 'b0000, 0, 0,   0, 0, 0,  1, 'b0000);
        add( 44, 0, 'b0000, 0, 0,   0, 0, 0,  1, 'b0000);
        add( 50, 0, 'b0000, 0, 1,   0, 0, 0,  1, 'b0000);
        add( 51, 0, 'b0000, 0, 0,   0, 1, 0,  1, 'b0000);
        add( 60, 0, 'b0000, 1, 0,   0, 1, 0,  1, 'b0000);
        add( 61, 0, 'b0010, 0, 0,   0, 1, 1,  1, 'b0000);
        add( 62, 0, 'b0000, 0, 0,   0, 0, 0,  2, 'b0000);
        add( 63, 0, 'b0000, 0, 0,   0, 0, 0,  2, 'b0000);
        add( 68, 0, 'b0000, 0, 1,   0, 0, 0,  2, 'b0000);
        add( 69, 0, 'b0000, 0, 0,   0, 1, 0,  2, 'b0000);
        add(120, 0, 'b1000, 0, 0,   0, 1, 0,  2, 'b0000);
        add(122, 0, 'b0000, 1, 0,   0, 1, 0,  2, 'b1000);
        add(123, 0, 'b0000, 0, 0,   0, 1, 0,  2, 'b0000);
        add(124, 0, 'b0010, 0, 0,   0, 1, 0,  2, 'b0000);
        add(125, 0, 'b0000, 0, 0,   1, 1, 0,  2, 'b0010);
        add(130, 0, 'b0000, 1, 0,   1, 1, 0,  2, 'b0010);
        add(132, 0, 'b0000, 0, 0,   1, 1, 0,  2, 'b0000);
        add(133, 0, 'b0000, 0, 0,   0, 1, 0,  2, 'b0000);

        add(  0, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add(  1, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 70, 1, 'b0111, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 71, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0111);
        add( 80, 1, 'b0000, 1, 0,   0, 1, 0,  0, 'b0111);
        add( 81, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 83, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 90, 1, 'b1111, 0, 0,   0, 1, 0,  0, 'b0000);
        add( 91, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b1111);
        add(100, 1, 'b0000, 1, 0,   0, 1, 0,  0, 'b1111);
        add(101, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add(102, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b0000);
        add(103, 1, 'b0000, 0, 0,   1, 1, 0,  0, 'b0000);
        add(110, 1, 'b1111, 0, 0,   1, 1, 0,  0, 'b0000);
        add(111, 1, 'b1111, 1, 0,   1, 1, 0,  0, 'b1111);
        add(112, 1, 'b1111, 1, 0,   1, 1, 0,  0, 'b1111);
        add(113, 1, 'b0000, 0, 0,   1, 1, 0,  0, 'b1111);
        add(114, 1, 'b0000, 0, 0,   0, 1, 0,  0, 'b1111);
        add(115, 1, 'b0000, 0, 0,   1, 1, 0,  0, 'b1111);

        // reset with non-zero line levels so the detectors load them
        repeat (3) @(posedge clk);
        #1;
        a0 = 4'b1010; tick0 = 1'b1; a1 = 4'b0101; tick1 = 1'b1;
        step();
        rst_n = 1'b1;

        for (int c = 0; c <= 140; c++) begin
            clr0 = 1'b0;
            clr1 = 1'b0;
            foreach (tbl[k]) begin
                if (tbl[k].cyc == c) begin
                    if (tbl[k].sel == 1'b0) begin
                        a0 = a0 ^ tbl[k].ta; tick0 = tick0 ^ tbl[k].tt; clr0 = clr0 | tbl[k].clr;
                    end else begin
                        a1 = a1 ^ tbl[k].ta; tick1 = tick1 ^ tbl[k].tt; clr1 = clr1 | tbl[k].clr;
                    end
                end
            end
            @(negedge clk);
            foreach (tbl[k]) begin
                if (tbl[k].cyc == c) begin
                    if (tbl[k].sel == 1'b0) begin
                        chk("or_q",     c, 32'(q0), 32'(tbl[k].q));
                        chk("or_q_vld", c, 32'(v0), 32'(tbl[k].vld));
                        chk("or_err",   c, 32'(e0), 32'(tbl[k].err));
                        chk("or_cnt",   c, 32'(c0), 32'(tbl[k].cnt));
                        chk("or_st",    c, 32'(s0), 32'(tbl[k].st));
                    end else begin
                        chk("and_q",     c, 32'(q1), 32'(tbl[k].q));
                        chk("and_q_vld", c, 32'(v1), 32'(tbl[k].vld));
                        chk("and_err",   c, 32'(e1), 32'(tbl[k].err));
                        chk("and_cnt",   c, 32'(c1), 32'(tbl[k].cnt));
                        chk("and_st",    c, 32'(s1), 32'(tbl[k].st));
                    end
                end
            end
            step();
        end

        // 300 same-cycle data+tick setup violations: counter saturates
        clr0 = 1'b0;
        bad  = 0;
        for (int i = 0; i < 300; i++) begin
            a0[0] = ~a0[0];
            tick0 = ~tick0;
            @(negedge clk);
            if (e0 !== 1'b1) bad++;
            step();
        end
        @(negedge clk);
        chk("sat_err_each", 0, 32'(bad), 32'd0);
        chk("sat_cnt",      0, 32'(c0), 32'd255);
        chk("sat_err_idle", 0, 32'(e0), 32'd0);
        chk("sat_q_vld",    0, 32'(v0), 32'd0);
        step();

        // fire in flight when reset hits: it must never reach q
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        a0[1] = ~a0[1];
        step();
        step();
        step();
        step();
        tick0 = ~tick0;
        @(negedge clk);
        chk("rst_pre_err", 0, 32'(e0), 32'd0);
        chk("rst_pre_st",  0, 32'(s0), 32'b0010);
        chk("rst_pre_q",   0, 32'(q0), 32'd0);
        step();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_q",     0, 32'(q0), 32'd0);
        chk("rst_q_vld", 0, 32'(v0), 32'd1);
        chk("rst_err",   0, 32'(e0), 32'd0);
        chk("rst_cnt",   0, 32'(c0), 32'd0);
        chk("rst_st",    0, 32'(s0), 32'd0);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (q0 !== 1'b0) bad++;
            step();
        end
        chk("rst_no_toggle", 0, 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
